// File: rtl/mem_ctrl_pkg.sv
// Shared command encodings and controller state for the memory command path.
package mem_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_CLEAR = 2'b11
  } mem_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CLEAR
  } mem_state_t;
endpackage

// File: rtl/mem_bank.sv
// Single-port RAM: synchronous write, registered read. It has no reset so it
// maps onto block RAM.
module mem_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write when enabled; otherwise read the addressed word into the register.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end
endmodule

// File: rtl/mem_cmd_ctrl.sv
// Memory command controller: accepts one WRITE/READ/CLEAR per rising edge of
// ioCmdDoneIn while idle, runs it against mem_bank and reports completion.
module mem_cmd_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [1:0]        memCmdIn,
  input  logic [63:0]       memAddrIn,
  input  logic [DATA_W-1:0] ioDataIn,
  input  logic              ioCmdDoneIn,
  output logic              memCmdDoneOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic              errOut
);
  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic              prev_q, prev_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  mem_cmd_t          cmd;
  logic              req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign cmd = mem_cmd_t'(memCmdIn);
  // Edges seen while busy still update prev, so they are consumed, not queued.
  assign req = ioCmdDoneIn & ~prev_q;

  // Writes are gated by rstN so a reset edge never commits a pending write.
  assign ram_we    = rstN & (((state_q == ST_WRITE) & ~oor_q) | (state_q == ST_CLEAR));
  assign ram_addr  = (state_q == ST_CLEAR) ? cnt_q : addr_q;
  assign ram_wdata = (state_q == ST_CLEAR) ? '0 : wdata_q;

  mem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Next-state, latch and output logic for the command FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    prev_d  = ioCmdDoneIn;
    done_d  = done_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req && cmd != CMD_NOP) begin
          addr_d  = memAddrIn[ADDR_W-1:0];
          wdata_d = ioDataIn;
          oor_d   = |memAddrIn[63:ADDR_W];
          cnt_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          case (cmd)
            CMD_WRITE: state_d = ST_WRITE;
            CMD_READ:  state_d = ST_RD_ADDR;
            default:   state_d = ST_CLEAR;
          endcase
        end
      end
      ST_WRITE: begin
        err_d   = oor_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_ADDR: begin
        if (oor_q) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        data_d  = ram_rdata;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      prev_q  <= 1'b1;
      done_q  <= 1'b1;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      prev_q  <= prev_d;
      done_q  <= done_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign memCmdDoneOut = done_q;
  assign memDataOut    = data_q;
  assign errOut        = err_q;
endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Scoreboard bench for mem_cmd_ctrl: stimulus pushes expected completions
// from a word-array model, a monitor pops them when done returns high.
module tb_mem_cmd_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  memCmdIn;
  logic [63:0] memAddrIn;
  logic [31:0] ioDataIn;
  logic        ioCmdDoneIn;
  logic        memCmdDoneOut;
  logic [31:0] memDataOut;
  logic        errOut;

  mem_cmd_ctrl dut (
    .clk          (clk),
    .rstN         (rstN),
    .memCmdIn     (memCmdIn),
    .memAddrIn    (memAddrIn),
    .ioDataIn     (ioDataIn),
    .ioCmdDoneIn  (ioCmdDoneIn),
    .memCmdDoneOut(memCmdDoneOut),
    .memDataOut   (memDataOut),
    .errOut       (errOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          low;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mm[256];
  logic [31:0] m_data;
  logic        m_err;
  int          passed = 0;
  int          total  = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
    else passed++;
  endtask

  // Reference model: effect of one accepted command, pushed as an expectation.
  task automatic model_apply(input mem_cmd_t c, input logic [63:0] a, input logic [31:0] d);
    bit oor = (a >> 8) != 64'd0;
    int lo  = int'(a[7:0]);
    int low;
    case (c)
      CMD_NOP: return;
      CMD_WRITE: begin
        low = 1;
        m_err = oor;
        if (!oor) mm[lo] = d;
      end
      CMD_READ: begin
        m_err = oor;
        low = oor ? 1 : 2;
        if (!oor) m_data = mm[lo];
      end
      default: begin
        low = 256;
        m_err = 1'b0;
        for (int i = 0; i < 256; i++) mm[i] = 32'h0;
      end
    endcase
    exp_q.push_back('{low: low, data: m_data, err: m_err});
  endtask

  task automatic drive(input mem_cmd_t c, input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    memCmdIn = c; memAddrIn = a; ioDataIn = d; ioCmdDoneIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ioCmdDoneIn = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (memCmdDoneOut !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (memCmdDoneOut !== 1'b1) begin
      total++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", memCmdDoneOut, n);
    end
  endtask

  task automatic run(input mem_cmd_t c, input logic [63:0] a, input logic [31:0] d);
    model_apply(c, a, d);
    drive(c, a, d);
    wait_done();
  endtask

  // Monitor: measure low time of done and check each completion.
  initial begin
    int lowcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (memCmdDoneOut === 1'b0) lowcnt++;
        else if (lowcnt > 0) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: completion after %0d low cycles, required none", lowcnt);
          end else begin
            e = exp_q.pop_front();
            chk("done_low_cycles", 64'(lowcnt), 64'(e.low));
            chk("mem_data_out", 64'(memDataOut), 64'(e.data));
            chk("err_out", 64'(errOut), 64'(e.err));
          end
          lowcnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] hi;
    logic [63:0] a;
    int r;
    m_data = 32'h0;
    m_err  = 1'b0;
    // Reset with the request line already high: no command must issue.
    rstN = 1'b0; ioCmdDoneIn = 1'b1; memCmdIn = CMD_WRITE;
    memAddrIn = 64'h5; ioDataIn = 32'h1111_2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_done", 64'(memCmdDoneOut), 64'd1);
    chk("reset_data", 64'(memDataOut), 64'd0);
    chk("reset_err", 64'(errOut), 64'd0);
    ioCmdDoneIn = 1'b0;

    // Write / read-back.
    run(CMD_WRITE, 64'h0F, 32'hDEAD_BEEF);
    run(CMD_READ,  64'h0F, 32'h0);

    // Clear over seeded end words.
    run(CMD_WRITE, 64'h00, 32'hA5A5_A5A5);
    run(CMD_WRITE, 64'hFF, 32'hA5A5_A5A5);
    run(CMD_CLEAR, 64'h0,  32'h0);
    run(CMD_READ,  64'h00, 32'h0);
    run(CMD_READ,  64'hFF, 32'h0);

    // Out-of-range read keeps data, then a valid write clears the error.
    run(CMD_WRITE, 64'h20,  32'h1234_5678);
    run(CMD_READ,  64'h20,  32'h0);
    run(CMD_READ,  64'h100, 32'h0);
    run(CMD_WRITE, 64'h21,  32'h0000_0042);
    run(CMD_WRITE, 64'h8000_0000_0000_0003, 32'hFFFF_0000);
    run(CMD_READ,  64'h03,  32'h0);

    // A request while clearing is dropped.
    model_apply(CMD_CLEAR, 64'h0, 32'h0);
    drive(CMD_CLEAR, 64'h0, 32'h0);
    repeat (10) @(negedge clk);
    memCmdIn = CMD_WRITE; memAddrIn = 64'h10; ioDataIn = 32'h1; ioCmdDoneIn = 1'b1;
    @(negedge clk);
    ioCmdDoneIn = 1'b0;
    wait_done();
    run(CMD_READ, 64'h10, 32'h0);

    // Randomized mix.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      a = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        hi = {$urandom, $urandom};
        if (hi == 56'h0) hi = 56'h1;
        a = {hi, a[7:0]};
      end
      if (r < 5)       run(CMD_NOP,   a, $urandom);
      else if (r < 50) run(CMD_WRITE, a, $urandom);
      else if (r < 98) run(CMD_READ,  a, 32'h0);
      else             run(CMD_CLEAR, a, 32'h0);
    end

    // Reset in the middle of a clear over a full memory.
    for (int i = 0; i < 256; i++) run(CMD_WRITE, 64'(i), 32'hFFFF_FFFF);
    drive(CMD_CLEAR, 64'h0, 32'h0);
    for (int i = 0; i < 99; i++) mm[i] = 32'h0;
    m_data = 32'h0;
    m_err  = 1'b0;
    exp_q.push_back('{low: 100, data: 32'h0, err: 1'b0});
    repeat (99) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    chk("mid_reset_done", 64'(memCmdDoneOut), 64'd1);
    for (int i = 0; i < 256; i++) run(CMD_READ, 64'(i), 32'h0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_cmd_ctrl.md
# mem_cmd_ctrl

Memory command controller sitting directly downstream of the switch/button I/O controller. Accepts one command (write, read, clear) per handshake, executes it against an internal synchronous word-addressed memory, and returns read data plus a completion flag. The flag and data feed back to the I/O controller's `memCmdDoneIn` / `memDataIn` inputs.

## Interface
Parameters:
- `ADDR_W`, 8: implemented address bits; depth = 2^ADDR_W words.
- `DATA_W`, 32: word width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rstN`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `memCmdIn`  in  2  command code: 00 NOP, 01 WRITE, 10 READ, 11 CLEAR.
- `memAddrIn`  in  64  word address; only `[ADDR_W-1:0]` indexes memory.
- `ioDataIn`  in  DATA_W  write data.
- `ioCmdDoneIn`  in  1  I/O side has finished assembling the command; a rising edge requests execution.
- `memCmdDoneOut`  out  1  1 = idle / last command complete; 0 = busy.
- `memDataOut`  out  DATA_W  result of the last successful READ.
- `errOut`  out  1  last command had an out-of-range address.

## Operation
- States: IDLE, WRITE, RD_ADDR, RD_DATA, CLEAR.
- Request = rising edge of `ioCmdDoneIn`, detected with a registered copy `prevDone`. `prevDone` resets to 1, so a level already high at reset release does not issue a command.
- IDLE plus request plus `memCmdIn` != NOP:
  - latch command, `memAddrIn` and `ioDataIn`;
  - clear `errOut`;
  - drive `memCmdDoneOut` low;
  - branch to the command state.
- IDLE plus request with NOP: ignored; done stays 1 and `errOut` is unchanged.
- Range check applies to WRITE and READ: any nonzero `memAddrIn[63:ADDR_W]` is out of range.
  - The memory is not accessed and `memDataOut` is unchanged.
  - `errOut` is set to 1.
  - The state returns to IDLE with done = 1 one cycle after accept.
- WRITE: writes the latched data to the latched address, then returns to IDLE with done = 1.
- READ: RD_ADDR presents the address to the RAM. RD_DATA registers the RAM output into `memDataOut`, then returns to IDLE with done = 1.
- CLEAR: a counter runs from 0 to 2^ADDR_W-1 and writes 0 to one word per cycle. After the last word it returns to IDLE with done = 1. CLEAR ignores the address field.
- Requests that arrive while busy are dropped, not queued. `prevDone` still tracks the input, so that edge is consumed.

## Timing
- Accept edge = E0. `memCmdDoneOut` is 0 from E0.
  - WRITE: RAM updated at E1; done = 1 after E1 (1 low cycle).
  - READ: address registered at E1; `memDataOut` valid and done = 1 after E2 (2 low cycles).
  - CLEAR: words 0..N-1 written at E1..EN, N = 2^ADDR_W; done = 1 after EN (N low cycles; 256 with the default).
  - Range error: `errOut` = 1 and done = 1 after E1.
- `memDataOut` changes only at RD_DATA.
- Reset values:
  - `memCmdDoneOut` = 1, `memDataOut` = 0, `errOut` = 0;
  - state IDLE, clear counter 0, `prevDone` = 1.
- RAM contents are not reset.
- Reset mid-operation aborts immediately. A partial CLEAR leaves words at and above the counter untouched, and an in-flight WRITE at E1 with `rstN` = 0 is not committed.
- RAM is single-port with synchronous write and 1-cycle registered read. Read and write never occur in the same cycle.

## Structure
- Package `mem_ctrl_pkg`:
  - `mem_cmd_t` enum (NOP/WRITE/READ/CLEAR, 2 bits);
  - `mem_state_t` enum;
  - `DATA_W_DEF`, `ADDR_W_DEF`.
  - Shared with the I/O controller so command encodings cannot diverge.
- Sub-module `mem_bank`: parameterised single-port RAM (`clk`, `we`, `addr`, `wdata`, `rdata`), with no reset, so it infers block RAM.
- Controller FSM, edge detect, latches and clear counter live in `mem_cmd_ctrl`.

## Test plan
- Reset then idle: hold `rstN` = 0 for 3 cycles with `ioCmdDoneIn` = 1, then release. Required: done = 1, `memDataOut` = 0, `errOut` = 0, and no command issued.
- Write/read-back: WRITE addr 0x0F, data 0xDEADBEEF, then READ 0x0F. Required: done low 1 cycle and 2 cycles respectively, and `memDataOut` = 0xDEADBEEF two edges after the READ accept.
- Clear: write 0xA5A5A5A5 to 0x00 and 0xFF, then CLEAR. Required: done low exactly 256 cycles, and reads of 0x00 and 0xFF return 0.
- Out of range: READ addr 0x100 after `memDataOut` = 0x12345678. Required: `errOut` = 1, `memDataOut` still 0x12345678, done back high after 1 cycle; a following valid WRITE clears `errOut`.
- Busy drop: during CLEAR, pulse `ioCmdDoneIn` with a WRITE 0x10 / 0x1. Required: ignored, and word 0x10 reads 0 after the clear.
- Reset mid-clear: assert `rstN` at E100 of a CLEAR over a fully 0xFFFFFFFF memory. Required: words 0..98 = 0, words 99..255 = 0xFFFFFFFF, done = 1 after reset.
